// File: rtl/st7920_pkg.sv
// Shared definitions for the ST7920 character-mode text controller:
// command bytes, the DDRAM row address table and the FSM state types.
package st7920_pkg;

    localparam logic [7:0] FUNC_BASIC = 8'h30;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] ENTRY_INC  = 8'h06;

    // Set-DDRAM-address commands for the first column of each text row.
    localparam logic [7:0] LINE_ADDR [0:3] = '{8'h80, 8'h90, 8'h88, 8'h98};

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT0,
        ST_INIT1,
        ST_INIT2,
        ST_INIT3,
        ST_IDLE,
        ST_ROWADDR,
        ST_FETCH,
        ST_CHAR,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EN,
        WR_WAIT,
        WR_ACK
    } wr_state_e;

    function automatic logic [7:0] line_addr(input logic [1:0] row);
        return LINE_ADDR[row];
    endfunction

endpackage

// File: rtl/st7920_bus_writer.sv
// Single-byte ST7920 bus writer: one setup cycle with rs/dat driven, EN_CYC
// cycles of lcd_en high, then a post-write delay (CLR_CYC for CLEAR, CMD_CYC
// otherwise) before a one-cycle ack. rs/dat stay put until the next request.
module st7920_bus_writer
    import st7920_pkg::*;
#(
    parameter int EN_CYC  = 25,
    parameter int CMD_CYC = 4000,
    parameter int CLR_CYC = 80000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] dat,
    output logic       ack,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_dat
);

    localparam int MAX_AB  = (EN_CYC > CMD_CYC) ? EN_CYC : CMD_CYC;
    localparam int MAX_CYC = (MAX_AB > CLR_CYC) ? MAX_AB : CLR_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    wr_state_e      state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [CW-1:0]  wait_last;
    logic           rs_nx;
    logic [7:0]     dat_nx;

    // State, shared delay counter and the held bus byte.
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WR_IDLE;
            cnt     <= '0;
            lcd_rs  <= 1'b0;
            lcd_dat <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            lcd_rs  <= rs_nx;
            lcd_dat <= dat_nx;
        end
    end

    // Next-state logic: accept a request only when idle, then time EN and the post-write wait.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rs_nx     = lcd_rs;
        dat_nx    = lcd_dat;
        wait_last = (!lcd_rs && lcd_dat == CLEAR) ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);
        case (state)
            WR_IDLE: begin
                if (req) begin
                    state_nx = WR_SETUP;
                    rs_nx    = rs;
                    dat_nx   = dat;
                end
            end
            WR_SETUP: begin
                state_nx = WR_EN;
                cnt_nx   = '0;
            end
            WR_EN: begin
                if (cnt == CW'(EN_CYC - 1)) begin
                    state_nx = WR_WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WR_WAIT: begin
                if (cnt == wait_last) begin
                    state_nx = WR_ACK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WR_ACK:  state_nx = WR_IDLE;
            default: state_nx = WR_IDLE;
        endcase
    end

    assign lcd_en = (state == WR_EN);
    assign ack    = (state == WR_ACK);

endmodule

// File: rtl/st7920_text_ctrl.sv
// ST7920 character-mode controller: power-up wait, four init commands, then
// on request rewrites a ROWS x COLS character RAM onto the panel row by row.
// Build option: define ST7920_AUTO_REFRESH_EN for back-to-back continuous frames
// (refresh_req ignored, busy held high).
module st7920_text_ctrl
    import st7920_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 16,
    parameter int AW        = 6,
    parameter int PWRUP_CYC = 2000000,
    parameter int EN_CYC    = 25,
    parameter int CMD_CYC   = 4000,
    parameter int CLR_CYC   = 80000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          refresh_req,
    output logic          busy,
    output logic          frame_done,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_data,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_dat
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW  = $clog2(PWRUP_CYC + 1);

    state_e          state, state_nx;
    logic [RW-1:0]   row, row_nx;
    logic [CLW-1:0]  col, col_nx;
    logic [PW-1:0]   pwr_cnt, pwr_cnt_nx;
    logic            wr_req, wr_rs, wr_ack;
    logic [7:0]      wr_dat;
    logic            start;

`ifdef ST7920_AUTO_REFRESH_EN
    assign start = 1'b1;
    assign busy  = 1'b1;
`else
    assign start = refresh_req;
    assign busy  = (state != ST_IDLE);
`endif

    assign frame_done = (state == ST_DONE);
    assign lcd_rw     = 1'b0;
    // row/col return to 0 at frame end, so the address never passes ROWS*COLS-1.
    assign ram_addr   = AW'(row) * AW'(COLS) + AW'(col);

    st7920_bus_writer #(
        .EN_CYC  (EN_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC)
    ) u_writer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wr_req),
        .rs      (wr_rs),
        .dat     (wr_dat),
        .ack     (wr_ack),
        .lcd_en  (lcd_en),
        .lcd_rs  (lcd_rs),
        .lcd_dat (lcd_dat)
    );

    // Sequencer state, text cursor and power-up counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_PWRUP;
            row     <= '0;
            col     <= '0;
            pwr_cnt <= '0;
        end else begin
            state   <= state_nx;
            row     <= row_nx;
            col     <= col_nx;
            pwr_cnt <= pwr_cnt_nx;
        end
    end

    // Sequencer: issue one writer request per state and advance on its ack.
    always_comb begin
        state_nx   = state;
        row_nx     = row;
        col_nx     = col;
        pwr_cnt_nx = pwr_cnt;
        wr_req     = 1'b0;
        wr_rs      = 1'b0;
        wr_dat     = '0;
        case (state)
            ST_PWRUP: begin
                if (pwr_cnt == PW'(PWRUP_CYC - 1)) state_nx = ST_INIT0;
                else                               pwr_cnt_nx = pwr_cnt + PW'(1);
            end
            ST_INIT0: begin
                wr_req = 1'b1;
                wr_dat = FUNC_BASIC;
                if (wr_ack) state_nx = ST_INIT1;
            end
            ST_INIT1: begin
                wr_req = 1'b1;
                wr_dat = DISP_ON;
                if (wr_ack) state_nx = ST_INIT2;
            end
            ST_INIT2: begin
                wr_req = 1'b1;
                wr_dat = CLEAR;
                if (wr_ack) state_nx = ST_INIT3;
            end
            ST_INIT3: begin
                wr_req = 1'b1;
                wr_dat = ENTRY_INC;
                if (wr_ack) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    row_nx   = '0;
                    col_nx   = '0;
                    state_nx = ST_ROWADDR;
                end
            end
            ST_ROWADDR: begin
                wr_req = 1'b1;
                wr_dat = line_addr(2'(row));
                if (wr_ack) state_nx = ST_FETCH;
            end
            // ram_addr is presented here; the writer latches ram_data one cycle later in CHAR.
            ST_FETCH: state_nx = ST_CHAR;
            ST_CHAR: begin
                wr_req = 1'b1;
                wr_rs  = 1'b1;
                wr_dat = ram_data;
                if (wr_ack) begin
                    if (col == CLW'(COLS - 1)) begin
                        col_nx = '0;
                        if (row == RW'(ROWS - 1)) begin
                            row_nx   = '0;
                            state_nx = ST_DONE;
                        end else begin
                            row_nx   = row + RW'(1);
                            state_nx = ST_ROWADDR;
                        end
                    end else begin
                        col_nx   = col + CLW'(1);
                        state_nx = ST_FETCH;
                    end
                end
            end
`ifdef ST7920_AUTO_REFRESH_EN
            ST_DONE: state_nx = ST_ROWADDR;
`else
            ST_DONE: state_nx = ST_IDLE;
`endif
            default: state_nx = ST_PWRUP;
        endcase
    end

endmodule
